axis_frame_type_demux: RTL and testbench
========================================

Name: axis_frame_type_demux

Overview:
- Downstream of the frame-type checker on the 256-bit ingress AXI-Stream path.
- Buffers the first beat of each frame until the checker's registered frame_type is valid.
- Steers the whole frame to one of three egress queues: critical, PTP or IT.
- Keeps per-class frame counters for debug and statistics.

Parameters:
DATA_WIDTH, 256, AXIS data width in bits.
KEEP_WIDTH, 32, tkeep width (DATA_WIDTH/8).
CNT_WIDTH, 32, width of each per-class frame counter.

Ports:
axis_aclk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
s_axis_tdata  in  DATA_WIDTH  ingress data
s_axis_tkeep  in  KEEP_WIDTH  ingress byte enables
s_axis_tvalid  in  1  ingress valid
s_axis_tready  out  1  ingress ready
s_axis_tlast  in  1  ingress end of frame
frame_type  in  2  classifier result: 0 critical, 1 PTP, 2 IT, 3 reserved; valid the cycle after the first beat handshake
m_axis_tdata  out  DATA_WIDTH  egress data, shared by all ports
m_axis_tkeep  out  KEEP_WIDTH  egress byte enables, shared
m_axis_tlast  out  1  egress end of frame, shared
m_axis_tvalid  out  3  per-port valid: bit0 critical, bit1 PTP, bit2 IT; at most one bit set
m_axis_tready  in  3  per-port ready, same bit mapping
cnt_crit  out  CNT_WIDTH  completed critical frames
cnt_ptp  out  CNT_WIDTH  completed PTP frames
cnt_it  out  CNT_WIDTH  completed IT frames

Behaviour:
- Clock axis_aclk; reset rst, synchronous, active-high.
- Reset values:
  - State IDLE; hold_valid=0; last_in=0; sel=2.
  - m_axis_tvalid=3'b000; m_axis_tdata/tkeep/tlast=0; counters=0; s_axis_tready=0 while rst is high.
- Datapath: one hold register (data, keep, last) plus hold_valid. m_axis_tdata/tkeep/tlast are driven directly from the hold register. m_axis_tvalid[sel]=hold_valid, but only in FORWARD.
- s_axis_tready never depends on s_axis_tvalid.
- IDLE:
  - s_axis_tready=1.
  - Any beat accepted in IDLE is the first beat of a frame. Capture it into hold, set hold_valid=1, last_in=s_axis_tlast, go to CLASSIFY.
- CLASSIFY (exactly 1 cycle):
  - s_axis_tready=0.
  - Register sel from frame_type; 3 maps to 2 (IT).
  - Go to FORWARD.
- FORWARD:
  - s_axis_tready = ~last_in & (~hold_valid | m_axis_tready[sel]).
  - Output handshake: hold_valid & m_axis_tready[sel].
  - Input handshake loads hold (hold_valid=1, last_in|=s_axis_tlast). Otherwise an output handshake clears hold_valid.
  - When the output handshake carries tlast=1: increment the counter selected by sel, clear last_in, go to IDLE.
- Latency:
  - First beat accepted at cycle T; CLASSIFY at T+1; first egress valid at T+2.
  - Subsequent beats pass with 1-cycle latency at full rate when not backpressured.
  - Each frame costs at least 2 idle input cycles: the CLASSIFY cycle plus the IDLE re-entry.
- Boundaries:
  - No beat of the next frame is accepted while the current frame's last beat is held or pending (last_in=1), so frame_type always refers to the frame in hold.
  - Backpressure on the selected port stalls input only. Unselected m_axis_tready bits are ignored.
  - Data and beat order are preserved; no drops or duplicates.
  - Counters wrap modulo 2^CNT_WIDTH without saturation.
  - rst mid-frame: the held beat is discarded and the state returns to IDLE. The next accepted beat is treated as a first beat; no resynchronisation to frame boundaries.

Test Plan:
- Single-beat frame accepted at T, frame_type=0 at T+1, m_axis_tready=3'b111 -> m_axis_tvalid=3'b001 with tlast=1 at T+2; cnt_crit=1 at T+3; s_axis_tready=1 again at T+3.
- 4-beat frame, frame_type=1, tready continuously high -> four beats on bit1 at T+2..T+5, data/keep identical and in order; s_axis_tready=0 at T+1; cnt_ptp=1.
- 3-beat frame, frame_type=2, m_axis_tready[2] pattern 1,0,1,0,1 -> exactly 3 egress handshakes, no loss or duplication; s_axis_tready low whenever hold is full and tready[2]=0.
- frame_type=3 -> frame egresses on bit2; cnt_it increments; cnt_crit and cnt_ptp unchanged.
- Two frames back-to-back with s_axis_tvalid held high -> s_axis_tready=0 from the cycle after frame 1's tlast is accepted until IDLE; frame 2 classified from its own frame_type (0 then 1) and routed accordingly.
- rst asserted during beat 2 of a 4-beat frame -> next cycle m_axis_tvalid=0, all counters 0, s_axis_tready=1 after rst deasserts.

Source files
------------

// File: rtl/axis_frame_type_demux.sv
// AXI-Stream frame-type demultiplexer.
// Holds the first beat of each frame until the upstream classifier's
// registered frame_type is available, then steers the whole frame to one
// of three egress ports (critical, PTP, IT). One hold register carries every
// beat, so throughput is one beat per cycle inside a frame, with a two-cycle
// gap between frames (classification cycle plus IDLE re-entry).
// Per-class counters count completed frames and wrap silently.
module axis_frame_type_demux #(
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  axis_aclk,
  input  logic                  rst,
  // Ingress
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  // Classifier result, valid the cycle after the first-beat handshake
  input  logic [1:0]            frame_type,
  // Egress: shared payload, per-port valid/ready (bit0 crit, bit1 PTP, bit2 IT)
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic [2:0]            m_axis_tvalid,
  input  logic [2:0]            m_axis_tready,
  // Statistics
  output logic [CNT_WIDTH-1:0]  cnt_crit,
  output logic [CNT_WIDTH-1:0]  cnt_ptp,
  output logic [CNT_WIDTH-1:0]  cnt_it
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_CLASSIFY = 2'd1;
  localparam logic [1:0] ST_FORWARD  = 2'd2;

  localparam logic [1:0] SEL_CRIT = 2'd0;
  localparam logic [1:0] SEL_PTP  = 2'd1;
  localparam logic [1:0] SEL_IT   = 2'd2;

  logic [1:0]            r_state;
  logic [DATA_WIDTH-1:0] r_hold_data;
  logic [KEEP_WIDTH-1:0] r_hold_keep;
  logic                  r_hold_last;
  logic                  r_hold_valid;
  logic                  r_last_in;   // current frame's tlast has been accepted
  logic [1:0]            r_sel;
  logic [CNT_WIDTH-1:0]  r_cnt_crit;
  logic [CNT_WIDTH-1:0]  r_cnt_ptp;
  logic [CNT_WIDTH-1:0]  r_cnt_it;

  logic                  w_sel_ready;
  logic [2:0]            w_tvalid;
  logic                  w_s_ready;
  logic                  w_in_hs;
  logic                  w_out_hs;

  // Ready of the selected egress port; unselected ready bits are ignored.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case statement can leave it unassigned and infer a latch.
    w_sel_ready = 1'b0;
    case (r_sel)
      SEL_CRIT: w_sel_ready = m_axis_tready[0];
      SEL_PTP:  w_sel_ready = m_axis_tready[1];
      default:  w_sel_ready = m_axis_tready[2];
    endcase
  end

  // Egress valid goes to the selected port only, and only while forwarding.
  always_comb begin
    w_tvalid = 3'b000;
    if (r_state == ST_FORWARD) begin
      case (r_sel)
        SEL_CRIT: w_tvalid[0] = r_hold_valid;
        SEL_PTP:  w_tvalid[1] = r_hold_valid;
        default:  w_tvalid[2] = r_hold_valid;
      endcase
    end
  end

  // Ingress ready: never a function of s_axis_tvalid. Closed during
  // classification and once the frame's last beat is in, so frame_type
  // always belongs to the frame sitting in the hold register.
  always_comb begin
    w_s_ready = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_IDLE:    w_s_ready = 1'b1;
        ST_FORWARD: w_s_ready = ~r_last_in & (~r_hold_valid | w_sel_ready);
        default:    w_s_ready = 1'b0;
      endcase
    end
  end

  assign w_in_hs  = s_axis_tvalid & w_s_ready;
  assign w_out_hs = (r_state == ST_FORWARD) & r_hold_valid & w_sel_ready;

  // Frame FSM, hold register and per-class counters.
  always_ff @(posedge axis_aclk) begin
    if (rst) begin
      // NOTE: the hold payload is reset too, because it drives m_axis_tdata
      // directly and egress must read as zero out of reset.
      r_state      <= ST_IDLE;
      r_hold_data  <= '0;
      r_hold_keep  <= '0;
      r_hold_last  <= 1'b0;
      r_hold_valid <= 1'b0;
      r_last_in    <= 1'b0;
      r_sel        <= SEL_IT;
      r_cnt_crit   <= '0;
      r_cnt_ptp    <= '0;
      r_cnt_it     <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge register values regardless of statement order.
      case (r_state)
        ST_IDLE: begin
          if (w_in_hs) begin
            r_hold_data  <= s_axis_tdata;
            r_hold_keep  <= s_axis_tkeep;
            r_hold_last  <= s_axis_tlast;
            r_hold_valid <= 1'b1;
            r_last_in    <= s_axis_tlast;
            r_state      <= ST_CLASSIFY;
          end
        end

        ST_CLASSIFY: begin
          // Reserved type 3 is treated as IT.
          r_sel   <= (frame_type == 2'd3) ? SEL_IT : frame_type;
          r_state <= ST_FORWARD;
        end

        ST_FORWARD: begin
          if (w_in_hs) begin
            r_hold_data  <= s_axis_tdata;
            r_hold_keep  <= s_axis_tkeep;
            r_hold_last  <= s_axis_tlast;
            r_hold_valid <= 1'b1;
            r_last_in    <= r_last_in | s_axis_tlast;
          end else if (w_out_hs) begin
            r_hold_valid <= 1'b0;
          end
          // An input handshake cannot coincide with the final output beat,
          // because input is closed once last_in is set.
          if (w_out_hs && r_hold_last) begin
            case (r_sel)
              SEL_CRIT: r_cnt_crit <= r_cnt_crit + 1'b1;
              SEL_PTP:  r_cnt_ptp  <= r_cnt_ptp + 1'b1;
              default:  r_cnt_it   <= r_cnt_it + 1'b1;
            endcase
            r_last_in <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_axis_tready = w_s_ready;
  assign m_axis_tdata  = r_hold_data;
  assign m_axis_tkeep  = r_hold_keep;
  assign m_axis_tlast  = r_hold_last;
  assign m_axis_tvalid = w_tvalid;
  assign cnt_crit      = r_cnt_crit;
  assign cnt_ptp       = r_cnt_ptp;
  assign cnt_it        = r_cnt_it;

endmodule

// File: tb/tb_axis_frame_type_demux.sv
// Self-checking bench for axis_frame_type_demux. The driver pushes each
// expected egress beat into a queue as it is offered; an independent
// monitor pops and compares on every egress handshake.
module tb_axis_frame_type_demux;

  localparam int DW = 256;
  localparam int KW = 32;
  localparam int CW = 32;

  typedef struct {
    int          port;
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic        last;
  } beat_t;

  logic          axis_aclk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [KW-1:0] s_axis_tkeep = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic [1:0]    frame_type = 2'd0;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tlast;
  logic [2:0]    m_axis_tvalid;
  logic [2:0]    m_axis_tready;
  logic [CW-1:0] cnt_crit;
  logic [CW-1:0] cnt_ptp;
  logic [CW-1:0] cnt_it;

  logic [2:0] tr_base = 3'b000;
  logic       pat_en  = 1'b0;
  logic       pat_bit = 1'b1;
  assign m_axis_tready = {pat_en ? pat_bit : tr_base[2], tr_base[1:0]};

  int    n_checks = 0;
  int    n_pass   = 0;
  int    cyc      = 0;
  beat_t exp_q[$];

  axis_frame_type_demux #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .CNT_WIDTH(CW)) dut (
    .axis_aclk    (axis_aclk),
    .rst          (rst),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tkeep (s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast (s_axis_tlast),
    .frame_type   (frame_type),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .cnt_crit     (cnt_crit),
    .cnt_ptp      (cnt_ptp),
    .cnt_it       (cnt_it)
  );

  always #5 axis_aclk = ~axis_aclk;

  always @(posedge axis_aclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] mk_data(input logic [7:0] tag, input int beat);
    logic [DW-1:0] d;
    for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = {tag, 8'(beat), 8'(w), 8'h5A};
    return d;
  endfunction

  // Alternating ready on the IT port while enabled: 1,0,1,0,...
  initial forever begin
    @(posedge axis_aclk);
    #2;
    if (!pat_en) pat_bit = 1'b1;
    else         pat_bit = ~pat_bit;
  end

  // Monitor: compares every egress handshake against the scoreboard.
  initial forever begin
    beat_t e;
    @(negedge axis_aclk);
    if (!rst && m_axis_tvalid != 3'b000) begin
      check("tvalid_onehot", DW'($onehot(m_axis_tvalid)), 1);
      for (int p = 0; p < 3; p++) begin
        if (m_axis_tvalid[p] && !m_axis_tready[p])
          check("stall_blocks_input", DW'(s_axis_tready), 0);
        if (m_axis_tvalid[p] && m_axis_tready[p]) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("egress_port", DW'(p), DW'(e.port));
            check("egress_data", m_axis_tdata, e.data);
            check("egress_keep", DW'(m_axis_tkeep), DW'(e.keep));
            check("egress_last", DW'(m_axis_tlast), DW'(e.last));
          end
        end
      end
    end
  end

  // Sends one frame; expected port is supplied by the caller. Also checks
  // the classification cycle and first-egress latency.
  task automatic send_frame(input logic [1:0] ft, input int port, input int n,
                            input logic [7:0] tag, output int first_cyc, output int last_cyc);
    logic  acc;
    int    waited;
    beat_t b;
    logic [1:0] decoy;
    decoy = (ft == 2'd0) ? 2'd1 : 2'd0;
    frame_type = decoy;
    first_cyc = 0;
    last_cyc  = 0;
    for (int i = 0; i < n; i++) begin
      b.port = port;
      b.data = mk_data(tag, i);
      b.keep = (i == n - 1) ? 32'h0000_0FFF : 32'hFFFF_FFFF;
      b.last = (i == n - 1);
      exp_q.push_back(b);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = b.data;
      s_axis_tkeep  = b.keep;
      s_axis_tlast  = b.last;
      acc = 1'b0;
      waited = 0;
      while (!acc && waited < 200) begin
        @(negedge axis_aclk);
        acc = s_axis_tready;
        @(posedge axis_aclk);
        #1;
        waited++;
      end
      if (!acc) begin
        check("accept_timeout", 0, 1);
        return;
      end
      if (i == 0) begin
        first_cyc = cyc;
        // Classification cycle: input closed, nothing on egress yet.
        frame_type = ft;
        check("classify_no_ready", DW'(s_axis_tready), 0);
        check("classify_no_valid", DW'(m_axis_tvalid), 0);
        @(posedge axis_aclk);
        #1;
        frame_type = decoy;
        check("first_valid_latency", DW'(m_axis_tvalid), DW'(3'b001 << port));
      end
      if (i == n - 1) begin
        last_cyc = cyc;
        check("closed_after_last", DW'(s_axis_tready), 0);
      end
    end
  endtask

  task automatic drain();
    int waited = 0;
    s_axis_tvalid = 1'b0;
    while (exp_q.size() != 0 && waited < 100) begin
      @(posedge axis_aclk);
      waited++;
    end
    @(posedge axis_aclk);
    #1;
    check("drain_empty", DW'(exp_q.size()), 0);
  endtask

  task automatic check_cnts(input int c, input int p, input int t);
    check("cnt_crit", DW'(cnt_crit), DW'(c));
    check("cnt_ptp",  DW'(cnt_ptp),  DW'(p));
    check("cnt_it",   DW'(cnt_it),   DW'(t));
  endtask

  initial begin
    int f1, l1, f2, l2;
    logic acc;
    int waited;

    // Reset values.
    repeat (3) @(posedge axis_aclk);
    @(negedge axis_aclk);
    check("rst_s_ready", DW'(s_axis_tready), 0);
    check("rst_tvalid",  DW'(m_axis_tvalid), 0);
    check("rst_tdata",   m_axis_tdata, 0);
    check("rst_tlast",   DW'(m_axis_tlast), 0);
    check_cnts(0, 0, 0);
    @(posedge axis_aclk);
    #1;
    rst = 1'b0;
    #1;
    check("idle_s_ready", DW'(s_axis_tready), 1);

    // Single-beat critical frame.
    tr_base = 3'b111;
    send_frame(2'd0, 0, 1, 8'h11, f1, l1);
    s_axis_tvalid = 1'b0;
    @(posedge axis_aclk);
    #1;
    check("single_cnt_crit", DW'(cnt_crit), 1);
    check("single_ready_back", DW'(s_axis_tready), 1);
    drain();

    // Four-beat PTP frame at full rate.
    send_frame(2'd1, 1, 4, 8'h22, f1, l1);
    drain();
    check_cnts(1, 1, 0);

    // Three-beat IT frame with alternating ready; other ready bits high.
    tr_base = 3'b011;
    pat_en  = 1'b1;
    send_frame(2'd2, 2, 3, 8'h33, f1, l1);
    drain();
    pat_en = 1'b0;
    check_cnts(1, 1, 1);

    // Reserved type goes to IT; only the IT port is ready.
    tr_base = 3'b100;
    send_frame(2'd3, 2, 2, 8'h44, f1, l1);
    drain();
    check_cnts(1, 1, 2);

    // Back-to-back frames, tvalid held: two-cycle gap, each routed by its own type.
    tr_base = 3'b111;
    send_frame(2'd0, 0, 2, 8'h55, f1, l1);
    send_frame(2'd1, 1, 2, 8'h66, f2, l2);
    check("b2b_gap", DW'(f2 - l1), 2);
    drain();
    check_cnts(2, 2, 2);

    // Reset in the middle of a frame while beat 2 is stalled.
    tr_base = 3'b000;
    frame_type = 2'd1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = mk_data(8'h77, 0);
    s_axis_tkeep  = '1;
    s_axis_tlast  = 1'b0;
    acc = 1'b0;
    waited = 0;
    while (!acc && waited < 50) begin
      @(negedge axis_aclk);
      acc = s_axis_tready;
      @(posedge axis_aclk);
      #1;
      waited++;
    end
    check("midrst_first_accept", DW'(acc), 1);
    @(posedge axis_aclk);
    #1;
    s_axis_tdata = mk_data(8'h77, 1);
    @(negedge axis_aclk);
    check("midrst_stalled", DW'(s_axis_tready), 0);
    @(posedge axis_aclk);
    #1;
    rst = 1'b1;
    @(posedge axis_aclk);
    #1;
    check("midrst_tvalid", DW'(m_axis_tvalid), 0);
    check("midrst_s_ready", DW'(s_axis_tready), 0);
    check("midrst_tdata", m_axis_tdata, 0);
    check_cnts(0, 0, 0);
    rst = 1'b0;
    s_axis_tvalid = 1'b0;
    #1;
    check("postrst_s_ready", DW'(s_axis_tready), 1);

    // Next beat after reset starts a fresh frame.
    tr_base = 3'b111;
    send_frame(2'd0, 0, 1, 8'h88, f1, l1);
    drain();
    check_cnts(1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
